piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per accepted serial beat.
- Serial side uses a valid/ready handshake with a last-bit flag.
- It is the read-out end for 32-bit register data: parallel words captured by register banks are transmitted to a bit-serial link or checker.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_tx_if.sv | 25 ++
 rtl/piso_bitcnt.sv | 22 ++
 rtl/piso_tx.sv | 61 ++++++
 tb/tb_piso_tx.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width; it only has to hold WIDTH-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load and serial handshakes of piso_tx; master is the host/link side, slave is the transmitter.
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_out;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_out, ser_last, busy
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_out, ser_last, busy
  );
endinterface

// File: rtl/piso_bitcnt.sv
// Loadable down-counter with zero flag; load wins over dec.
module piso_bitcnt #(
  parameter int W = 5
) (
  input  logic         CK,
  input  logic         RD_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge CK) begin
    if (!RD_N)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word out per WIDTH accepted serial beats.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic CK,
  input  logic RD_N,
  piso_tx_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             in_shift;
  logic             beat;
  logic             last;
  logic             accept;

  assign in_shift = (state == SHIFT);
  assign last     = in_shift && cnt_zero;
  assign beat     = in_shift && bus.ser_ready;
  // Integrators: load_ready depends combinationally on ser_ready so a new
  // word can load on the last-beat edge without a bubble.
  assign bus.load_ready = RD_N && (!in_shift || (last && bus.ser_ready));
  assign accept         = bus.load_valid && bus.load_ready;

  always_ff @(posedge CK) begin
    if (!RD_N) begin
      state <= IDLE;
      sr    <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= bus.load_data;
    end else if (beat) begin
      sr <= LSB_FIRST ? (sr >> 1) : (sr << 1);
      if (last) state <= IDLE;
    end
  end

  // Counter parks at zero after the final beat rather than wrapping.
  piso_bitcnt #(.W(CW)) u_bitcnt (
    .CK       (CK),
    .RD_N     (RD_N),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (beat && !last),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign bus.ser_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.ser_last  = last;
  assign bus.ser_out   = LSB_FIRST ? sr[0] : sr[WIDTH-1];

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: 32-bit LSB-first and 8-bit MSB-first instances.
module tb_piso_tx;
  logic CK = 1'b0;
  logic RD_N;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CK = ~CK;

  piso_tx_if #(.WIDTH(32)) b32 ();
  piso_tx_if #(.WIDTH(8))  b8  ();

  piso_tx #(.WIDTH(32), .LSB_FIRST(1'b1)) dut32 (.CK(CK), .RD_N(RD_N), .bus(b32));
  piso_tx #(.WIDTH(8),  .LSB_FIRST(1'b0)) dut8  (.CK(CK), .RD_N(RD_N), .bus(b8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  w8;
    logic [3:0]  pat;
    int beats, c;

    // Reset with load_valid asserted
    RD_N = 1'b0;
    b32.load_valid = 1'b1; b32.load_data = 32'h5555_5555; b32.ser_ready = 1'b0;
    b8.load_valid  = 1'b0; b8.load_data  = 8'h00;         b8.ser_ready  = 1'b0;
    tick(); tick();
    chk("rst_load_ready", b32.load_ready, 0);
    chk("rst_ser_valid",  b32.ser_valid,  0);
    chk("rst_ser_out",    b32.ser_out,    0);
    chk("rst_ser_last",   b32.ser_last,   0);
    chk("rst_busy",       b32.busy,       0);
    chk("rst_load_ready8", b8.load_ready, 0);
    RD_N = 1'b1; b32.load_valid = 1'b0;
    #1;
    chk("post_rst_load_ready", b32.load_ready, 1);

    // Single word, LSB first, ser_ready held high
    w = 32'hA5A5_0F01;
    b32.load_data = w; b32.load_valid = 1'b1; b32.ser_ready = 1'b1;
    tick();
    b32.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("single_valid", b32.ser_valid, 1);
      chk("single_bit",   b32.ser_out,   w[i]);
      chk("single_last",  b32.ser_last,  (i == 31));
      tick();
    end
    chk("single_idle_valid", b32.ser_valid, 0);
    chk("single_idle_busy",  b32.busy,      0);
    chk("single_idle_ready", b32.load_ready, 1);

    // Back-to-back: all ones then all zeros, load_valid held
    b32.load_data = 32'hFFFF_FFFF; b32.load_valid = 1'b1;
    tick();
    b32.load_data = 32'h0000_0000;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) b32.load_valid = 1'b0;
      #1;
      chk("b2b_valid", b32.ser_valid, 1);
      chk("b2b_bit",   b32.ser_out,   (i < 32) ? 1 : 0);
      chk("b2b_last",  b32.ser_last,  (i == 31 || i == 63));
      if (i == 5)  chk("b2b_busy_not_ready", b32.load_ready, 0);
      if (i == 31) chk("b2b_last_ready",     b32.load_ready, 1);
      tick();
    end
    chk("b2b_idle", b32.ser_valid, 0);

    // Backpressure with ser_ready pattern 1,0,0,1
    w = 32'h8000_0001; pat = 4'b1001;
    b32.load_data = w; b32.load_valid = 1'b1; b32.ser_ready = 1'b1;
    tick();
    b32.load_valid = 1'b0;
    beats = 0; c = 0;
    while (beats < 32 && c < 200) begin
      b32.ser_ready = pat[3 - (c % 4)];
      #1;
      chk("bp_valid", b32.ser_valid, 1);
      chk("bp_bit",   b32.ser_out,   w[beats]);
      chk("bp_last",  b32.ser_last,  (beats == 31));
      if (b32.ser_ready) beats++;
      tick();
      c++;
    end
    chk("bp_beats", beats, 32);
    chk("bp_cycles", c, 64);
    chk("bp_idle_busy", b32.busy, 0);
    b32.ser_ready = 1'b1;

    // Reset in the middle of a word
    w = 32'h1234_5678;
    b32.load_data = w; b32.load_valid = 1'b1;
    tick();
    b32.load_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("mid_bit", b32.ser_out, w[i]);
      tick();
    end
    RD_N = 1'b0;
    tick();
    chk("mid_rst_valid", b32.ser_valid, 0);
    chk("mid_rst_busy",  b32.busy,      0);
    chk("mid_rst_out",   b32.ser_out,   0);
    chk("mid_rst_last",  b32.ser_last,  0);
    RD_N = 1'b1;
    w = 32'h0F0F_3C3C;
    b32.load_data = w; b32.load_valid = 1'b1;
    tick();
    b32.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("fresh_bit",  b32.ser_out,  w[i]);
      chk("fresh_last", b32.ser_last, (i == 31));
      tick();
    end
    chk("fresh_idle", b32.ser_valid, 0);

    // MSB-first 8-bit instance
    w8 = 8'hC3;
    b8.load_data = w8; b8.load_valid = 1'b1; b8.ser_ready = 1'b1;
    tick();
    b8.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("msb_valid", b8.ser_valid, 1);
      chk("msb_bit",   b8.ser_out,   w8[7 - i]);
      chk("msb_last",  b8.ser_last,  (i == 7));
      tick();
    end
    chk("msb_idle", b8.ser_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
